// File: rtl/uart_param_pkg.sv
// rtl/uart_param_pkg.sv - shared constants, FSM state types and baud divisor helper for uart_param
package uart_param_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Clocks per 16x oversampling tick, rounded down and never below one
    function automatic int calc_divisor(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * 16);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - 16x oversampling tick generator with synchronous clear
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running 0..DIV-1 counter; clear restarts the period so bit timing aligns to the triggering event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parameterised UART transmitter and receiver; UART_PARAM_RX_MAJORITY_EN selects 2-of-3 RX bit voting
module uart_param #(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_out,
    output logic                 rx_done,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    import uart_param_pkg::*;

    localparam int DIV = calc_divisor(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic PAR_INV = (PARITY == PAR_ODD);
    localparam bit HAS_PAR = (PARITY != PAR_NONE);

`ifdef UART_PARAM_RX_MAJORITY_EN
    // Vote is resolved on the third of the three sample ticks
    localparam logic [3:0] SAMPLE_AT = 4'd8;
`else
    localparam logic [3:0] SAMPLE_AT = 4'd7;
`endif

    // ---------------- transmitter ----------------
    tx_state_t            tx_state;
    logic [3:0]           tx_tick_cnt;
    logic [2:0]           tx_bit_cnt;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic                 tx_tick;
    logic                 tx_accept;

    assign tx_accept = (tx_state == TX_IDLE) && tx_start;

    uart_baud_gen #(.DIV(DIV)) u_tx_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (tx_accept),
        .tick  (tx_tick)
    );

    // TX frame sequencer: one bit period is 16 ticks; tx is updated at each bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_shreg    <= '0;
            tx_par      <= 1'b0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
        end else begin
            tx_done <= 1'b0;
            if (tx_state == TX_IDLE) begin
                if (tx_start) begin
                    tx_shreg    <= tx_in;
                    tx_par      <= (^tx_in) ^ PAR_INV;
                    tx_tick_cnt <= '0;
                    tx_bit_cnt  <= '0;
                    tx          <= 1'b0;
                    tx_busy     <= 1'b1;
                    tx_state    <= TX_START;
                end
            end else if (tx_tick) begin
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
                if (tx_tick_cnt == 4'd15) begin
                    case (tx_state)
                        TX_START: begin
                            tx       <= tx_shreg[0];
                            tx_shreg <= tx_shreg >> 1;
                            tx_state <= TX_DATA;
                        end
                        TX_DATA: begin
                            if (tx_bit_cnt == LAST_DATA) begin
                                tx_bit_cnt <= '0;
                                if (HAS_PAR) begin
                                    tx       <= tx_par;
                                    tx_state <= TX_PARITY;
                                end else begin
                                    tx       <= 1'b1;
                                    tx_state <= TX_STOP;
                                end
                            end else begin
                                tx_bit_cnt <= tx_bit_cnt + 3'd1;
                                tx         <= tx_shreg[0];
                                tx_shreg   <= tx_shreg >> 1;
                            end
                        end
                        TX_PARITY: begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end
                        default: begin
                            if (tx_bit_cnt == LAST_STOP) begin
                                tx_bit_cnt <= '0;
                                tx_busy    <= 1'b0;
                                tx_done    <= 1'b1;
                                tx_state   <= TX_IDLE;
                            end else begin
                                tx_bit_cnt <= tx_bit_cnt + 3'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state;
    logic [3:0]           rx_tick_cnt;
    logic [2:0]           rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_par;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 rx_tick;
    logic                 rx_fall;
    logic                 rx_bit;

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle line is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = (rx_state == RX_IDLE) && rx_prev && !rx_sync;

    uart_baud_gen #(.DIV(DIV)) u_rx_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (rx_fall),
        .tick  (rx_tick)
    );

`ifdef UART_PARAM_RX_MAJORITY_EN
    logic [1:0] rx_early;

    // Capture the samples at ticks 7 and 8; tick 9 supplies the third vote live
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_early <= '0;
        end else if (rx_tick && rx_tick_cnt == 4'd6) begin
            rx_early[0] <= rx_sync;
        end else if (rx_tick && rx_tick_cnt == 4'd7) begin
            rx_early[1] <= rx_sync;
        end
    end

    assign rx_bit = (rx_early[0] & rx_early[1]) | (rx_early[0] & rx_sync) | (rx_early[1] & rx_sync);
`else
    assign rx_bit = rx_sync;
`endif

    // RX frame sequencer: sample mid-bit, advance at bit boundaries, finish early at the first stop sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_tick_cnt   <= '0;
            rx_bit_cnt    <= '0;
            rx_shreg      <= '0;
            rx_par        <= 1'b0;
            rx_out        <= '0;
            rx_done       <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (rx_state == RX_IDLE) begin
                if (rx_fall) begin
                    rx_tick_cnt <= '0;
                    rx_bit_cnt  <= '0;
                    rx_state    <= RX_START;
                end
            end else if (rx_tick) begin
                rx_tick_cnt <= rx_tick_cnt + 4'd1;
                if (rx_tick_cnt == SAMPLE_AT) begin
                    case (rx_state)
                        RX_START: begin
                            if (rx_bit) begin
                                rx_state <= RX_IDLE;
                            end
                        end
                        RX_DATA: begin
                            rx_shreg <= {rx_bit, rx_shreg[DATA_BITS-1:1]};
                        end
                        RX_PARITY: begin
                            rx_par <= rx_bit;
                        end
                        default: begin
                            rx_out        <= rx_shreg;
                            rx_done       <= 1'b1;
                            rx_parity_err <= HAS_PAR && (rx_par != ((^rx_shreg) ^ PAR_INV));
                            rx_frame_err  <= !rx_bit;
                            rx_state      <= RX_IDLE;
                        end
                    endcase
                end else if (rx_tick_cnt == 4'd15) begin
                    case (rx_state)
                        RX_START: begin
                            rx_state <= RX_DATA;
                        end
                        RX_DATA: begin
                            if (rx_bit_cnt == LAST_DATA) begin
                                rx_bit_cnt <= '0;
                                rx_state   <= HAS_PAR ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_cnt <= rx_bit_cnt + 3'd1;
                            end
                        end
                        RX_PARITY: begin
                            rx_state <= RX_STOP;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 1000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line rate in bits/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, meaning payload bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2, meaning transmitted stop bits.
REQ-006 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-007 SHALL have ports: tx_start input 1, send request; tx_in input DATA_BITS, payload to send.
REQ-008 SHALL have ports: tx output 1, serial out; tx_busy output 1, frame in progress; tx_done output 1, one-cycle frame-complete pulse.
REQ-009 SHALL have ports: rx input 1, asynchronous serial in; rx_out output DATA_BITS, last received payload.
REQ-010 SHALL have ports: rx_done output 1, one-cycle receive pulse; rx_parity_err output 1 and rx_frame_err output 1, status qualified by rx_done.

Function
REQ-011 SHALL derive tick divisor D = CLK_FREQ/(BAUD*16), rounded down, minimum 1; one bit period = 16 ticks = 16*D clocks.
REQ-012 SHALL frame as start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1); tx idles high.
REQ-013 TX SHALL accept tx_start only when tx_busy=0; tx_start while busy is ignored and tx_in is not sampled.
REQ-014 On accept TX SHALL latch tx_in, clear its tick divider, drive tx low and assert tx_busy on the next cycle.
REQ-015 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0; each state holds tx for exactly one bit period per bit.
REQ-016 Parity SHALL be XOR of payload (even) or its inverse (odd).
REQ-017 TX SHALL pulse tx_done and deassert tx_busy in the cycle after the last stop bit period ends; tx_start in that same cycle is accepted.
REQ-018 RX SHALL pass rx through a two-flop synchronizer (reset value 1) before any use.
REQ-019 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a synchronized falling edge in IDLE clears the RX tick divider and enters START.
REQ-020 RX SHALL sample each bit at tick 8 of its bit period; a start sample of 1 is a false start and returns to IDLE with no rx_done.
REQ-021 RX SHALL check only the first stop bit, pulse rx_done one cycle after its sample, and return to IDLE (ready for the next falling edge).
REQ-022 rx_done SHALL be asserted even on error; rx_parity_err=1 on parity mismatch, rx_frame_err=1 on stop sample 0; both held with rx_out until next rx_done.
REQ-023 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-024 rst SHALL immediately force tx=1, tx_busy=0, tx_done=0, rx_out=0, rx_done=0, rx_parity_err=0, rx_frame_err=0, both FSMs to IDLE, all counters to 0.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; operation resumes on the first clk edge after rst deasserts.

Configuration
REQ-026 Macro UART_PARAM_RX_MAJORITY_EN defined: each RX bit SHALL be the 2-of-3 majority of samples at ticks 7, 8, 9; undefined: single sample at tick 8.

Structure
REQ-027 Package uart_param_pkg SHALL hold parity-mode constants, TX/RX state typedefs and the divisor computation function.
REQ-028 Sub-module uart_baud_gen SHALL produce the 16x tick with synchronous clear; instantiated once for TX and once for RX.

Verification (CLK_FREQ=1536000, BAUD=9600 -> D=10, bit=160 clocks)
REQ-029 8N1, tx_start with tx_in=0xA5 -> tx low 160 clocks then 1,0,1,0,0,1,0,1, stop high; tx_done exactly 1600 clocks after tx falls.
REQ-030 8E1 loopback tx->rx with 0x3C -> rx_done once, rx_out=0x3C, both errors 0; second tx_start during frame ignored.
REQ-031 8O1, drive frame 0x01 with parity bit inverted -> rx_done, rx_out=0x01, rx_parity_err=1, rx_frame_err=0.
REQ-032 8N1, drive 0x55 with stop bit 0 -> rx_done, rx_frame_err=1; next valid frame 0xAA received clean.
REQ-033 rx low for 40 clocks then high -> no rx_done, RX back in IDLE; with macro, one-clock glitch at tick 8 of a data bit does not corrupt rx_out.
REQ-034 rst asserted mid-TX and mid-RX -> tx=1 same cycle, no done pulses, next frame after release correct.
